jtag_dma_master: RTL and testbench
==================================

// Module: jtag_dma_master
// PURPOSE
//  Bus-master DMA engine downstream of the JTAG user-chain-1 register block.
//  Consumes one burst command (address, burst size, byte enables, direction) and moves data
//  between the shared dual-port burst buffer and the system bus. Reports busy/done/error
//  back to the chain (DMA_busy). Runs entirely in the system clock domain; command inputs
//  arrive already synchronised by the existing JTCK->clock CDC stage.
// PARAMETERS
//  BUF_ADDR_W    8      burst-buffer address width (max 256 beats)
//  TIMEOUT_CYCLES 1024  cycles without bus progress before abort with error
// PORTS
//  clock                   in   1   system clock, all logic on rising edge
//  reset                   in   1   synchronous, active-high
//  dmaStart                in   1   1-cycle pulse: launch command held on dma* inputs
//  dmaReadNotWrite         in   1   1 = bus->buffer, 0 = buffer->bus
//  dmaAddress              in   32  bus start address (word aligned)
//  dmaBurstSize            in   8   beats-1
//  dmaByteEnables          in   4   byte enables for every beat
//  dmaBusy                 out  1   command in progress
//  dmaDone                 out  1   1-cycle pulse on completion (also on abort)
//  dmaError                out  1   sticky; cleared on next accepted dmaStart
//  bufAddress              out  BUF_ADDR_W  buffer port address
//  bufWriteEnable          out  1   buffer write strobe
//  bufWriteData            out  32  buffer write data
//  bufReadData             in   32  buffer read data, 1-cycle latency from bufAddress
//  requestTransaction      out  1   bus request to arbiter
//  transactionGranted      in   1   arbiter grant
//  beginTransactionOut     out  1   1-cycle bus begin strobe
//  addressDataOut          out  32  address in begin cycle, data in write beats, else 0
//  readNotWriteOut, burstSizeOut[7:0], byteEnablesOut[3:0]  out  valid in begin cycle only, else 0
//  dataValidOut            out  1   write beat valid
//  endTransactionOut       out  1   1-cycle end strobe (writes and aborts)
//  addressDataIn           in   32  read data
//  dataValidIn, endTransactionIn, busyIn, busErrorIn  in  1 each  bus slave responses
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, beat counter 0, dmaError 0; reset mid-transfer aborts
//   silently (no endTransactionOut, no dmaDone).
//  FSM: IDLE -> REQUEST -> BEGIN -> {WRITE | READ} -> END -> IDLE; ERROR -> END.
//  IDLE: dmaStart latches all dma* inputs, clears dmaError, beats=0, dmaBusy=1 next cycle.
//   dmaStart while dmaBusy=1 is ignored.
//  REQUEST: requestTransaction=1 until transactionGranted; held through END.
//  BEGIN (1 cycle): beginTransactionOut=1 with address/size/rnw/byte enables; for writes
//   bufAddress=0 issued here (prefetch).
//  WRITE: dataValidOut=1, addressDataOut=bufReadData of current beat. A beat retires on a
//   cycle with busyIn=0; when busyIn=1 data and dataValidOut hold unchanged. Next
//   bufAddress issued so data is ready the cycle after retirement (no bubbles). After beat
//   dmaBurstSize retires -> END.
//  READ: every dataValidIn=1 writes addressDataIn to bufAddress=beat, beat+1.
//   endTransactionIn -> IDLE with dmaDone (no END cycle); beats beyond dmaBurstSize+1
//   are dropped and set dmaError.
//  END (1 cycle): endTransactionOut=1, requestTransaction drops next cycle, dmaDone=1, dmaBusy=0.
//  busErrorIn in BEGIN/WRITE/READ -> ERROR: dmaError=1, then END (write) or IDLE (read,
//   slave already ended). Watchdog counts cycles with no retired beat/no grant; reaching
//   TIMEOUT_CYCLES acts as busErrorIn. Counter reset on any progress.
//  Beat counter 8 bits; dmaBurstSize=255 gives 256 beats, no wrap before completion.
// STRUCTURE
//  jtag_dma_defs.vh: FSM state encoding, bus field widths, default timeout.
//  Sub-module jtag_dma_watchdog: loadable down-counter with progress-clear and expire flag.
// TESTING
//  1. Write, size 0 (1 beat), addr 0x55555555, buf[0]=0xABCDEF08, no busy -> one begin,
//     one beat 0xABCDEF08, endTransactionOut, dmaDone 1 cycle.
//  2. Write, 3 beats, busyIn high 2 cycles on beat 1 -> beat 1 data held stable, total
//     3 retired beats, contiguous bufAddress 0,1,2.
//  3. Read, 4 beats, slave returns 0x11..0x44 with gaps -> buf[0..3]=0x11,0x22,0x33,0x44;
//     dmaDone on endTransactionIn.
//  4. busErrorIn during write beat 2 -> dmaError=1, endTransactionOut, dmaDone, sticky until
//     next dmaStart.
//  5. Grant withheld TIMEOUT_CYCLES (set 16) -> dmaError=1, dmaDone; second dmaStart while busy ignored.
//  6. reset asserted mid-read -> all outputs 0 next cycle, new command then completes normally.

Source files
------------

// File: rtl/jtag_dma_master_pkg.sv
// Shared types and widths for the JTAG-side DMA bus master.
package jtag_dma_master_pkg;

  localparam int DATA_W          = 32;
  localparam int SIZE_W          = 8;
  localparam int BE_W            = 4;
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_BEGIN,
    ST_WRITE,
    ST_READ,
    ST_ERROR,
    ST_END
  } state_t;

  typedef struct packed {
    logic              rnw;
    logic [DATA_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [BE_W-1:0]   be;
  } dma_cmd_t;

endpackage

// File: rtl/jtag_dma_master_watchdog.sv
// Bus-progress watchdog: reloads while idle or on progress, expires on the
// TIMEOUT_CYCLES-th consecutive active cycle without progress.
module jtag_dma_master_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic progress,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active || progress)
      cnt_d = CNT_W'(TIMEOUT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  assign expired = active && !progress && (cnt_q <= CNT_W'(1));

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= CNT_W'(TIMEOUT_CYCLES);
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jtag_dma_master.sv
// Burst DMA master between the JTAG burst buffer and the system bus.
// One command at a time; reports busy/done/sticky error back to the chain.
module jtag_dma_master
  import jtag_dma_master_pkg::*;
#(
  parameter int BUF_ADDR_W     = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dmaStart,
  input  logic                  dmaReadNotWrite,
  input  logic [31:0]           dmaAddress,
  input  logic [7:0]            dmaBurstSize,
  input  logic [3:0]            dmaByteEnables,
  output logic                  dmaBusy,
  output logic                  dmaDone,
  output logic                  dmaError,
  output logic [BUF_ADDR_W-1:0] bufAddress,
  output logic                  bufWriteEnable,
  output logic [31:0]           bufWriteData,
  input  logic [31:0]           bufReadData,
  output logic                  requestTransaction,
  input  logic                  transactionGranted,
  output logic                  beginTransactionOut,
  output logic [31:0]           addressDataOut,
  output logic                  readNotWriteOut,
  output logic [7:0]            burstSizeOut,
  output logic [3:0]            byteEnablesOut,
  output logic                  dataValidOut,
  output logic                  endTransactionOut,
  input  logic [31:0]           addressDataIn,
  input  logic                  dataValidIn,
  input  logic                  endTransactionIn,
  input  logic                  busyIn,
  input  logic                  busErrorIn
);

  state_t      state_q, state_d;
  dma_cmd_t    cmd_q, cmd_d;
  logic [7:0]  beat_q, beat_d;
  logic        rd_full_q, rd_full_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        skip_end_q, skip_end_d;

  logic        wd_active, wd_progress, wd_expired, abort;

  assign wd_active   = (state_q == ST_REQUEST) || (state_q == ST_WRITE) || (state_q == ST_READ);
  assign wd_progress = ((state_q == ST_REQUEST) && transactionGranted) ||
                       ((state_q == ST_WRITE)   && !busyIn) ||
                       ((state_q == ST_READ)    && dataValidIn);
  assign abort       = busErrorIn || wd_expired;

  jtag_dma_master_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .active   (wd_active),
    .progress (wd_progress),
    .expired  (wd_expired)
  );

  always_comb begin
    state_d             = state_q;
    cmd_d               = cmd_q;
    beat_d              = beat_q;
    rd_full_d           = rd_full_q;
    err_d               = err_q;
    skip_end_d          = skip_end_q;
    done_d              = 1'b0;
    bufAddress          = '0;
    bufWriteEnable      = 1'b0;
    bufWriteData        = '0;
    requestTransaction  = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = '0;
    readNotWriteOut     = 1'b0;
    burstSizeOut        = '0;
    byteEnablesOut      = '0;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dmaStart) begin
          cmd_d     = '{rnw: dmaReadNotWrite, addr: dmaAddress,
                        size: dmaBurstSize, be: dmaByteEnables};
          err_d     = 1'b0;
          beat_d    = '0;
          rd_full_d = 1'b0;
          state_d   = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        requestTransaction = 1'b1;
        if (transactionGranted) begin
          state_d = ST_BEGIN;
        end else if (wd_expired) begin
          err_d      = 1'b1;
          skip_end_d = 1'b0;
          state_d    = ST_ERROR;
        end
      end
      ST_BEGIN: begin
        // bufAddress stays 0 here so beat 0 is already read out when WRITE starts
        requestTransaction  = 1'b1;
        beginTransactionOut = 1'b1;
        addressDataOut      = cmd_q.addr;
        readNotWriteOut     = cmd_q.rnw;
        burstSizeOut        = cmd_q.size;
        byteEnablesOut      = cmd_q.be;
        if (busErrorIn) begin
          err_d      = 1'b1;
          skip_end_d = 1'b0;
          state_d    = ST_ERROR;
        end else begin
          state_d = cmd_q.rnw ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        requestTransaction = 1'b1;
        dataValidOut       = 1'b1;
        addressDataOut     = bufReadData;
        // Re-address the current beat while stalled so the buffer output holds
        bufAddress         = BUF_ADDR_W'(beat_q);
        if (abort) begin
          err_d      = 1'b1;
          skip_end_d = 1'b0;
          state_d    = ST_ERROR;
        end else if (!busyIn) begin
          beat_d     = beat_q + 1'b1;
          bufAddress = BUF_ADDR_W'(beat_q + 1'b1);
          if (beat_q == cmd_q.size) state_d = ST_END;
        end
      end
      ST_READ: begin
        requestTransaction = 1'b1;
        bufAddress         = BUF_ADDR_W'(beat_q);
        if (abort) begin
          err_d      = 1'b1;
          skip_end_d = 1'b1;
          state_d    = ST_ERROR;
        end else begin
          if (dataValidIn) begin
            if (rd_full_q) begin
              err_d = 1'b1;
            end else begin
              bufWriteEnable = 1'b1;
              bufWriteData   = addressDataIn;
              beat_d         = beat_q + 1'b1;
              if (beat_q == cmd_q.size) rd_full_d = 1'b1;
            end
          end
          if (endTransactionIn) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        requestTransaction = 1'b1;
        state_d            = skip_end_q ? ST_IDLE : ST_END;
        done_d             = skip_end_q;
      end
      ST_END: begin
        requestTransaction = 1'b1;
        endTransactionOut  = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_END) done_d = 1'b1;
  end

  assign dmaBusy  = (state_q != ST_IDLE) && (state_q != ST_END);
  assign dmaDone  = done_q;
  assign dmaError = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      beat_q     <= '0;
      rd_full_q  <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      skip_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      beat_q     <= beat_d;
      rd_full_q  <= rd_full_d;
      err_q      <= err_d;
      done_q     <= done_d;
      skip_end_q <= skip_end_d;
    end
  end

endmodule

// File: tb/tb_jtag_dma_master.sv
// Scoreboard bench for jtag_dma_master: buffer model, bus monitor, directed commands.
module tb_jtag_dma_master;

  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          dmaStart, dmaReadNotWrite;
  logic [31:0]   dmaAddress;
  logic [7:0]    dmaBurstSize;
  logic [3:0]    dmaByteEnables;
  logic          dmaBusy, dmaDone, dmaError;
  logic [AW-1:0] bufAddress;
  logic          bufWriteEnable;
  logic [31:0]   bufWriteData, bufReadData;
  logic          requestTransaction, transactionGranted, beginTransactionOut;
  logic [31:0]   addressDataOut, addressDataIn;
  logic          readNotWriteOut, dataValidOut, endTransactionOut;
  logic [7:0]    burstSizeOut;
  logic [3:0]    byteEnablesOut;
  logic          dataValidIn, endTransactionIn, busyIn, busErrorIn;

  always #5 clock = ~clock;

  jtag_dma_master #(.BUF_ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .dmaStart(dmaStart), .dmaReadNotWrite(dmaReadNotWrite), .dmaAddress(dmaAddress),
    .dmaBurstSize(dmaBurstSize), .dmaByteEnables(dmaByteEnables),
    .dmaBusy(dmaBusy), .dmaDone(dmaDone), .dmaError(dmaError),
    .bufAddress(bufAddress), .bufWriteEnable(bufWriteEnable), .bufWriteData(bufWriteData),
    .bufReadData(bufReadData),
    .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
    .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
    .readNotWriteOut(readNotWriteOut), .burstSizeOut(burstSizeOut),
    .byteEnablesOut(byteEnablesOut), .dataValidOut(dataValidOut),
    .endTransactionOut(endTransactionOut), .addressDataIn(addressDataIn),
    .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn),
    .busyIn(busyIn), .busErrorIn(busErrorIn)
  );

  // Burst buffer model: 1-cycle read latency, preload port for the bench
  logic [31:0]   mem [256];
  logic [31:0]   rd_q;
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  always @(posedge clock) begin
    rd_q <= mem[bufAddress];
    if (bufWriteEnable) mem[bufAddress] <= bufWriteData;
    if (pl_we)          mem[pl_addr]    <= pl_data;
  end
  assign bufReadData = rd_q;

  logic auto_grant;
  assign transactionGranted = auto_grant & requestTransaction;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [44:0] exp_beg [$];
  logic [31:0] exp_wd  [$];
  logic [31:0] exp_rd  [$];
  int n_beg = 0, n_ret = 0, n_end = 0, n_done = 0;

  // Bus monitor, sampled mid-cycle once bench inputs have settled
  always @(negedge clock) begin
    if (!reset) begin
      if (beginTransactionOut) begin
        n_beg++;
        chk("beg_pending", exp_beg.size() > 0, 1);
        if (exp_beg.size() > 0)
          chk("beg_fields", {readNotWriteOut, addressDataOut, burstSizeOut, byteEnablesOut},
              exp_beg.pop_front());
      end
      if (dataValidOut && !busyIn && !busErrorIn) begin
        n_ret++;
        chk("wbeat_pending", exp_wd.size() > 0, 1);
        if (exp_wd.size() > 0) chk("wbeat_data", addressDataOut, exp_wd.pop_front());
      end
      if (dataValidOut && busyIn && exp_wd.size() > 0)
        chk("wbeat_hold", addressDataOut, exp_wd[0]);
      if (endTransactionOut) n_end++;
      if (dmaDone) n_done++;
    end
  end

  int bb, br, be_, bd;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic snap();
    bb = n_beg; br = n_ret; be_ = n_end; bd = n_done;
  endtask

  task automatic expect_counts(input string tag, input int b, input int r, input int e, input int d);
    chk({tag, "_begins"}, n_beg - bb, b);
    chk({tag, "_beats"},  n_ret - br, r);
    chk({tag, "_ends"},   n_end - be_, e);
    chk({tag, "_dones"},  n_done - bd, d);
  endtask

  task automatic load(input int a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = AW'(a); pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic start_cmd(input logic rnw, input logic [31:0] a, input logic [7:0] sz,
                           input logic [3:0] ben);
    dmaReadNotWrite = rnw; dmaAddress = a; dmaBurstSize = sz; dmaByteEnables = ben;
    dmaStart = 1'b1;
    step();
    dmaStart = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc, output int cyc);
    cyc = 0;
    while (cyc < maxc && n_done == bd) begin
      step();
      cyc++;
    end
    chk({tag, "_done_seen"}, n_done - bd, 1);
    step(2);
  endtask

  task automatic wait_cnt(input string tag, input int which, input int target);
    int i = 0;
    while (i < 60 && ((which == 0) ? (n_beg - bb) : (n_ret - br)) < target) begin
      step();
      i++;
    end
    chk({tag, "_reached"}, ((which == 0) ? (n_beg - bb) : (n_ret - br)) >= target, 1);
  endtask

  function automatic logic [63:0] out_flags();
    return {dmaBusy, dmaDone, dmaError, bufWriteEnable, requestTransaction,
            beginTransactionOut, readNotWriteOut, dataValidOut, endTransactionOut,
            burstSizeOut, byteEnablesOut};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int cyc;
    dmaStart = 0; dmaReadNotWrite = 0; dmaAddress = 0; dmaBurstSize = 0; dmaByteEnables = 0;
    addressDataIn = 0; dataValidIn = 0; endTransactionIn = 0; busyIn = 0; busErrorIn = 0;
    pl_we = 0; pl_addr = 0; pl_data = 0; auto_grant = 1;

    // Reset state
    step(3);
    chk("rst_flags", out_flags(), 0);
    chk("rst_addr_data", addressDataOut, 0);
    chk("rst_buf_addr", bufAddress, 0);
    reset = 1'b0;
    step();

    // 1: single-beat write
    load(0, 32'hABCDEF08);
    snap();
    exp_beg.push_back({1'b0, 32'h55555555, 8'd0, 4'hF});
    exp_wd.push_back(32'hABCDEF08);
    start_cmd(1'b0, 32'h55555555, 8'd0, 4'hF);
    chk("t1_busy", dmaBusy, 1);
    wait_done("t1", 40, cyc);
    expect_counts("t1", 1, 1, 1, 1);
    chk("t1_err", dmaError, 0);
    chk("t1_idle", dmaBusy, 0);

    // 2: 3-beat write with slave stall on beat 1
    for (int i = 0; i < 3; i++) load(i, 32'h10000001 + i * 32'h00110000);
    snap();
    exp_beg.push_back({1'b0, 32'h00001000, 8'd2, 4'h3});
    for (int i = 0; i < 3; i++) exp_wd.push_back(32'h10000001 + i * 32'h00110000);
    start_cmd(1'b0, 32'h00001000, 8'd2, 4'h3);
    wait_cnt("t2_beat0", 1, 1);
    busyIn = 1'b1;
    step(2);
    busyIn = 1'b0;
    wait_done("t2", 40, cyc);
    expect_counts("t2", 1, 3, 1, 1);

    // 3: 4-beat read with gaps
    for (int i = 0; i < 5; i++) load(i, 32'hDEAD0000 + i);
    snap();
    exp_beg.push_back({1'b1, 32'h00002000, 8'd3, 4'hF});
    start_cmd(1'b1, 32'h00002000, 8'd3, 4'hF);
    wait_cnt("t3_begin", 0, 1);
    for (int k = 0; k < 4; k++) begin
      dataValidIn = 1'b1; addressDataIn = 32'h11 * (k + 1);
      exp_rd.push_back(32'h11 * (k + 1));
      step();
      dataValidIn = 1'b0; addressDataIn = 0;
      step(k % 2 + 1);
    end
    endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    wait_done("t3", 20, cyc);
    expect_counts("t3", 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) chk("t3_buf", mem[i], exp_rd.pop_front());
    chk("t3_buf_untouched", mem[4], 32'hDEAD0004);
    chk("t3_err", dmaError, 0);

    // 4: bus error on write beat 2
    for (int i = 0; i < 4; i++) load(i, 32'h40000000 + i);
    snap();
    exp_beg.push_back({1'b0, 32'h00003000, 8'd3, 4'hF});
    for (int i = 0; i < 4; i++) exp_wd.push_back(32'h40000000 + i);
    start_cmd(1'b0, 32'h00003000, 8'd3, 4'hF);
    wait_cnt("t4_beats01", 1, 2);
    busErrorIn = 1'b1;
    step();
    busErrorIn = 1'b0;
    wait_done("t4", 20, cyc);
    expect_counts("t4", 1, 2, 1, 1);
    exp_wd.delete();
    step(5);
    chk("t4_err_sticky", dmaError, 1);

    // 5: grant withheld until the watchdog fires; second start while busy ignored
    auto_grant = 1'b0;
    snap();
    start_cmd(1'b0, 32'h00004000, 8'd0, 4'hF);
    chk("t5_err_cleared", dmaError, 0);
    step(4);
    dmaAddress = 32'h44444444; dmaStart = 1'b1;
    step();
    dmaStart = 1'b0;
    wait_done("t5", 60, cyc);
    chk("t5_not_early", cyc >= 10, 1);
    expect_counts("t5", 0, 0, 1, 1);
    chk("t5_err", dmaError, 1);
    step(3);
    chk("t5_second_ignored", {dmaBusy, requestTransaction}, 0);
    auto_grant = 1'b1;

    // 6: reset mid-read, then a normal write
    snap();
    exp_beg.push_back({1'b1, 32'h00005000, 8'd3, 4'hF});
    start_cmd(1'b1, 32'h00005000, 8'd3, 4'hF);
    wait_cnt("t6_begin", 0, 1);
    dataValidIn = 1'b1; addressDataIn = 32'h99;
    step();
    dataValidIn = 1'b0; addressDataIn = 0;
    reset = 1'b1;
    step();
    chk("t6_rst_flags", out_flags(), 0);
    chk("t6_rst_addr_data", addressDataOut, 0);
    reset = 1'b0;
    step(3);
    expect_counts("t6_abort", 1, 0, 0, 0);
    load(0, 32'h60000000); load(1, 32'h60000001);
    snap();
    exp_beg.push_back({1'b0, 32'h00006000, 8'd1, 4'h5});
    exp_wd.push_back(32'h60000000); exp_wd.push_back(32'h60000001);
    start_cmd(1'b0, 32'h00006000, 8'd1, 4'h5);
    wait_done("t6", 40, cyc);
    expect_counts("t6", 1, 2, 1, 1);
    chk("t6_err", dmaError, 0);

    // 7: maximum burst, 256 beats without wrap
    for (int i = 0; i < 256; i++) load(i, {8'(i), 8'(~i), 16'hBEEF});
    snap();
    exp_beg.push_back({1'b0, 32'h00007000, 8'd255, 4'hF});
    for (int i = 0; i < 256; i++) exp_wd.push_back({8'(i), 8'(~i), 16'hBEEF});
    start_cmd(1'b0, 32'h00007000, 8'd255, 4'hF);
    wait_done("t7", 400, cyc);
    expect_counts("t7", 1, 256, 1, 1);

    // 8: read overrun beat is dropped and flags an error
    load(1, 32'h0000CAFE);
    snap();
    exp_beg.push_back({1'b1, 32'h00008000, 8'd0, 4'hF});
    start_cmd(1'b1, 32'h00008000, 8'd0, 4'hF);
    wait_cnt("t8_begin", 0, 1);
    dataValidIn = 1'b1; addressDataIn = 32'h77;
    step();
    addressDataIn = 32'h88;
    step();
    dataValidIn = 1'b0; endTransactionIn = 1'b1;
    step();
    endTransactionIn = 1'b0;
    wait_done("t8", 20, cyc);
    chk("t8_err", dmaError, 1);
    chk("t8_buf0", mem[0], 32'h77);
    chk("t8_buf1_kept", mem[1], 32'h0000CAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
